// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches over a req/ready handshake,
// holds each instruction until it is retired and resolves the next PC.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        reset,

    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,

    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic        instr_valid,
    input  logic        instr_ready,

    output logic [31:0] pc,
    output logic [31:0] pc_plus4,

    input  logic        branch_taken,
    input  logic [15:0] branch_imm,
    input  logic        jump,
    input  logic [25:0] jump_index,
    input  logic        jr,
    input  logic [31:0] jr_target,

    output logic        fetch_err,
    output logic        halted
);

    typedef enum logic [1:0] {
        REQ   = 2'd0,
        ISSUE = 2'd1,
        HALT  = 2'd2
    } fetchState;

    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

    fetchState   state;
    fetchState   nextState;
    logic [15:0] waitCount;

    logic [31:0] nextPc;
    logic [31:0] branchOffset;
    logic        loadInstr;
    logic        loadPc;
    logic        setErr;
    logic        clearCount;
    logic        incCount;

    // Branch offset is a signed word offset, so shift left by two after extension.
    assign branchOffset = {{14{branch_imm[15]}}, branch_imm, 2'b00};

    always_comb begin
        if (jr) begin
            nextPc = jr_target;
        end else if (jump) begin
            nextPc = {pc_plus4[31:28], jump_index, 2'b00};
        end else if (branch_taken) begin
            nextPc = pc_plus4 + branchOffset;
        end else begin
            nextPc = pc_plus4;
        end
    end

    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        nextState   = state;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        halted      = 1'b0;
        loadInstr   = 1'b0;
        loadPc      = 1'b0;
        setErr      = 1'b0;
        clearCount  = 1'b0;
        incCount    = 1'b0;

        case (state)
            REQ: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    loadInstr  = 1'b1;
                    clearCount = 1'b1;
                    nextState  = ISSUE;
                end else if (waitCount == TIMEOUT_LAST) begin
                    setErr    = 1'b1;
                    nextState = HALT;
                end else begin
                    incCount = 1'b1;
                end
            end
            ISSUE: begin
                instr_valid = 1'b1;
                if (instr_ready) begin
                    if (nextPc[1:0] != 2'b00) begin
                        setErr    = 1'b1;
                        nextState = HALT;
                    end else begin
                        loadPc    = 1'b1;
                        nextState = REQ;
                    end
                end
            end
            HALT: begin
                halted = 1'b1;
            end
            default: begin
                nextState = HALT;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= REQ;
        end else begin
            state <= nextState;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc        <= RESET_PC;
            pc_plus4  <= RESET_PC + 32'd4;
            instr     <= 32'h0;
            fetch_err <= 1'b0;
            waitCount <= 16'h0;
        end else begin
            if (loadInstr) begin
                instr <= imem_rdata;
            end
            if (loadPc) begin
                pc       <= nextPc;
                pc_plus4 <= nextPc + 32'd4;
            end
            if (setErr) begin
                fetch_err <= 1'b1;
            end
            if (clearCount) begin
                waitCount <= 16'h0;
            end else if (incCount) begin
                waitCount <= waitCount + 16'd1;
            end
        end
    end

    assign imem_addr = pc;
    assign opcode    = instr[31:26];

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Upstream stage of the single-cycle core: owns the PC, fetches from instruction memory over a req/ready handshake, and presents the instruction (and its 6-bit opcode) to the control decoder and datapath.
- Computes the next PC from redirect inputs driven by the control/datapath (Branch&Zero, Jump/JAL, JR).
- Holds each instruction until the core retires it.
- Detects fetch timeout and misaligned PC, then halts.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
- TIMEOUT, 255, max cycles spent in REQ waiting for imem_ready before error; range 1..65535.

Ports:
- clk  input  1  core clock, all state on rising edge
- reset  input  1  asynchronous, active-high reset
- imem_req  output  1  fetch request, held until imem_ready
- imem_addr  output  32  fetch address, equals pc
- imem_ready  input  1  memory response valid; imem_rdata sampled this cycle
- imem_rdata  input  32  fetched instruction word
- instr  output  32  registered current instruction
- opcode  output  6  instr[31:26], feeds control decoder
- instr_valid  output  1  instr is valid and awaiting retire
- instr_ready  input  1  core retires instr this cycle; redirect inputs sampled now
- pc  output  32  address of current instruction
- pc_plus4  output  32  pc+4, used for JAL link and branch base
- branch_taken  input  1  Branch AND ALU zero
- branch_imm  input  16  signed word offset from instr[15:0]
- jump  input  1  J/JAL
- jump_index  input  26  instr[25:0]
- jr  input  1  jump register
- jr_target  input  32  rs value
- fetch_err  output  1  sticky error, set on timeout or misaligned next PC
- halted  output  1  high in HALT state

Behaviour:
- States: REQ, ISSUE, HALT. Reset state is REQ.
- Reset values:
  - pc = RESET_PC, pc_plus4 = RESET_PC+4, instr = 0, opcode = 0.
  - instr_valid = 0, fetch_err = 0, halted = 0.
  - timeout counter = 0.
  - imem_req is combinational: 1 in REQ, else 0. It is 1 immediately after reset release.
- REQ:
  - imem_req = 1, imem_addr = pc; counter increments each cycle.
  - On imem_ready: instr <= imem_rdata, counter <= 0, go ISSUE.
  - Else if counter == TIMEOUT-1: fetch_err <= 1, go HALT.
  - If imem_ready and timeout occur in the same cycle, imem_ready wins.
- ISSUE:
  - instr_valid = 1; instr, pc and opcode are stable.
  - On instr_ready, next PC priority is jr > jump > branch_taken > sequential:
    - jr: jr_target
    - jump: {pc_plus4[31:28], jump_index, 2'b00}
    - branch_taken: pc_plus4 + (sign_extend(branch_imm) << 2), 32-bit modulo (wraps)
    - else: pc_plus4
  - If next PC[1:0] != 0: fetch_err <= 1, pc unchanged, go HALT.
  - Else pc <= next PC, pc_plus4 <= next PC + 4 (32-bit wrap), instr_valid <= 0, go REQ.
- HALT:
  - imem_req = 0, instr_valid = 0, halted = 1. Exit only by reset.
- Ignored inputs:
  - imem_ready outside REQ (stale response).
  - instr_ready outside ISSUE.
  - Redirect inputs when instr_ready = 0.
- Timing:
  - Latency: imem_ready in cycle N gives instr_valid = 1 in cycle N+1.
  - instr_ready in cycle M gives imem_req with the new address in cycle M+1.
  - Minimum 2 cycles per instruction.
- Reset mid-operation, in any state: immediate return to reset values. An outstanding memory response after reset is treated as a response to RESET_PC only if it arrives while in REQ.
- pc wrap: 32'hFFFF_FFFC + 4 = 0, no error.

Test Plan:
- Reset then sequential fetch:
  - Stimulus: reset released, imem_ready=1 each REQ, instr_ready=1 each ISSUE.
  - Required: imem_addr sequence 0,4,8,C; instr_valid pulses every 2nd cycle; opcode matches rdata[31:26] (0x23 for lw word 0x8C01_0000).
- Branch backward:
  - Stimulus: pc=0x10, branch_taken=1, branch_imm=16'hFFFC with instr_ready.
  - Required: next imem_addr = 0x14 - 16 = 0x04.
- Jump vs branch priority:
  - Stimulus: pc=0x1000_0000, jump=1, jump_index=26'h40, branch_taken=1.
  - Required: next pc = 0x1000_0100.
- JR misaligned:
  - Stimulus: jr=1, jr_target=0x0000_0102.
  - Required: fetch_err=1, halted=1, imem_req=0, pc unchanged; stays so until reset, which restores pc=RESET_PC.
- Timeout:
  - Stimulus: TIMEOUT=4, imem_ready held 0.
  - Required: fetch_err rises after 4 REQ cycles.
  - Repeat with imem_ready=1 on the 4th cycle: no error, instr_valid=1 next cycle.
- Stray handshakes:
  - Stimulus: imem_ready pulsed in ISSUE; instr_ready pulsed in REQ.
  - Required: instr and pc unchanged.
- Reset mid-REQ:
  - Stimulus: async reset asserted mid-REQ.
  - Required: outputs return to reset values without waiting for a clock edge.
